tm1638_page_sched: RTL

//  Display page scheduler in front of TM1638_LED_KEY_DRV. Holds up to 4 client pages
//  (32b hex data, dots, digit-suppress); shows one at a time: auto-rotation or key-held.

---
 rtl/tm1638_page_sched.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/tm1638_page_sched.sv
// Page scheduler in front of the TM1638 LED/key driver: holds 4 pages, rotates or holds,
// debounces navigation keys and only updates the driver inputs on a driver frame pulse.
module tm1638_page_sched #(
   parameter int C_FCK      = 48_000_000,
   parameter int C_DEB_MS   = 20,
   parameter int C_DWELL_MS = 2000
) (
   input  logic         CK_i,
   input  logic         XARST_i,
   input  logic [127:0] PAGE_BIN_i,
   input  logic [31:0]  PAGE_DOTS_i,
   input  logic [31:0]  PAGE_SUP_i,
   input  logic [3:0]   PAGE_VALID_i,
   input  logic [7:0]   KEYS_i,
   input  logic         FRAME_i,
   output logic [31:0]  BIN_DAT_o,
   output logic [7:0]   DOTS_o,
   output logic [7:0]   SUP_DIGITS_o,
   output logic [7:0]   LEDS_o,
   output logic [1:0]   PAGE_o,
   output logic         HOLD_o,
   output logic [7:0]   KEY_EVT_o
);

   localparam int TICK_CYC = C_FCK / 1000;
   localparam int DEB_CYC  = C_DEB_MS * TICK_CYC;
   localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam int DBW      = $clog2(DEB_CYC + 1);
   localparam int DWW      = $clog2(C_DWELL_MS + 1);

   logic [DBW-1:0] deb_cnt_q [8];
   logic [DBW-1:0] deb_cnt_d [8];
   logic [7:0]     stab_q, stab_d;
   logic [7:0]     evt_q, evt_d;
   logic [3:0]     cmd_q;
   logic [PW-1:0]  pre_q, pre_d;
   logic [DWW-1:0] dwell_q, dwell_d;
   logic [1:0]     page_q, page_d;
   logic           hold_q, hold_d;
   logic [31:0]    bin_q;
   logic [7:0]     dots_q, sup_q, leds_q;
   logic           tick, any_valid, chg;
   logic [3:0]     page_oh;

   function automatic logic [1:0] f_next(input logic [1:0] p, input logic [3:0] v);
      logic [1:0] r;
      logic [1:0] c;
      r = p;
      for (int i = 4; i >= 1; i--) begin
         c = p + 2'(i);
         if (v[c]) r = c;
      end
      return r;
   endfunction

   function automatic logic [1:0] f_prev(input logic [1:0] p, input logic [3:0] v);
      logic [1:0] r;
      logic [1:0] c;
      r = p;
      for (int i = 4; i >= 1; i--) begin
         c = p - 2'(i);
         if (v[c]) r = c;
      end
      return r;
   endfunction

   function automatic logic [1:0] f_home(input logic [1:0] p, input logic [3:0] v);
      logic [1:0] r;
      r = p;
      for (int i = 3; i >= 0; i--) begin
         if (v[i]) r = 2'(i);
      end
      return r;
   endfunction

   // Per-key debounce: a key's stable state follows raw only after DEB_CYC consecutive disagreements.
   always_comb begin
      stab_d = stab_q;
      for (int k = 0; k < 8; k++) begin
         deb_cnt_d[k] = '0;
         if (KEYS_i[k] != stab_q[k]) begin
            if (deb_cnt_q[k] == DBW'(DEB_CYC - 1)) begin
               stab_d[k] = KEYS_i[k];
            end else begin
               deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
            end
         end
      end
      evt_d = stab_d & ~stab_q;
   end

   assign tick      = (pre_q == PW'(TICK_CYC - 1));
   assign any_valid = |PAGE_VALID_i;
   assign pre_d     = tick ? '0 : pre_q + 1'b1;

   always_comb begin
      page_d = page_q;
      hold_d = hold_q ^ cmd_q[2];
      chg    = 1'b0;
      if (cmd_q[3]) begin
         page_d = f_home(page_q, PAGE_VALID_i);
         chg    = 1'b1;
      end else if (cmd_q[0]) begin
         page_d = f_next(page_q, PAGE_VALID_i);
         chg    = 1'b1;
      end else if (cmd_q[1]) begin
         page_d = f_prev(page_q, PAGE_VALID_i);
         chg    = 1'b1;
      end else if (!hold_q && tick && dwell_q == DWW'(C_DWELL_MS - 1)) begin
         page_d = f_next(page_q, PAGE_VALID_i);
         chg    = 1'b1;
      end else if (!PAGE_VALID_i[page_q] && any_valid) begin
         page_d = f_next(page_q, PAGE_VALID_i);
         chg    = 1'b1;
      end
      // Any page action, a HOLD/AUTO toggle, or staying in HOLD restarts the dwell.
      if (chg || hold_d || cmd_q[2]) begin
         dwell_d = '0;
      end else if (tick) begin
         dwell_d = dwell_q + 1'b1;
      end else begin
         dwell_d = dwell_q;
      end
   end

   assign page_oh = 4'b0001 << page_q;

   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         for (int k = 0; k < 8; k++) deb_cnt_q[k] <= '0;
         stab_q  <= '0;
         evt_q   <= '0;
         cmd_q   <= '0;
         pre_q   <= '0;
         dwell_q <= '0;
         page_q  <= '0;
         hold_q  <= 1'b0;
         bin_q   <= '0;
         dots_q  <= '0;
         sup_q   <= 8'hFF;
         leds_q  <= '0;
      end else begin
         for (int k = 0; k < 8; k++) deb_cnt_q[k] <= deb_cnt_d[k];
         stab_q  <= stab_d;
         evt_q   <= evt_d;
         cmd_q   <= evt_q[3:0];
         pre_q   <= pre_d;
         dwell_q <= dwell_d;
         page_q  <= page_d;
         hold_q  <= hold_d;
         // Frame loads the registered page, so a same-cycle page change shows next frame.
         if (FRAME_i) begin
            if (any_valid) begin
               bin_q  <= PAGE_BIN_i[32*page_q +: 32];
               dots_q <= PAGE_DOTS_i[8*page_q +: 8];
               sup_q  <= PAGE_SUP_i[8*page_q +: 8];
               leds_q <= {hold_q, 3'b000, page_oh};
            end else begin
               bin_q  <= '0;
               dots_q <= '0;
               sup_q  <= 8'hFF;
               leds_q <= {hold_q, 7'b0};
            end
         end
      end
   end

   assign BIN_DAT_o    = bin_q;
   assign DOTS_o       = dots_q;
   assign SUP_DIGITS_o = sup_q;
   assign LEDS_o       = leds_q;
   assign PAGE_o       = page_q;
   assign HOLD_o       = hold_q;
   assign KEY_EVT_o    = evt_q;

endmodule
